multdiv_seq_ctrl: RTL

//  Iterative signed 32x32 multiply / 32/32 divide unit for the processor's multdiv stage.

---
 rtl/multdiv_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multdiv_seq_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// One shared 2*WIDTH product/remainder register, WIDTH iterations, fixed latency for both ops.
module multdiv_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
    logic               r_q, w_q_nxt;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div, r_neg, r_div0, r_dovf;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_exc, w_exc_nxt;

    logic               w_start, w_last;
    logic               w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_hi_ext, w_a_ext, w_sum;
    logic [WIDTH:0]     w_top, w_diff;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt;

    assign w_start  = (r_state != S_RUN) && (ctrl_MULT || ctrl_DIV);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Magnitudes are WIDTH-bit unsigned, so |most-negative| is exactly 2^(WIDTH-1).
    assign w_a_neg  = data_operandA[WIDTH-1];
    assign w_b_neg  = data_operandB[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -data_operandA : data_operandA;
    assign w_abs_b  = w_b_neg ? -data_operandB : data_operandB;
    assign w_b_zero = (data_operandB == '0);
    assign w_ovf    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);

    // Booth step: add/sub in WIDTH+1 bits so the shifted-in sign is always correct.
    assign w_hi_ext = {r_prod[2*WIDTH-1], r_prod[2*WIDTH-1:WIDTH]};
    assign w_a_ext  = {r_opnd[WIDTH-1], r_opnd};
    always_comb begin
        w_sum = w_hi_ext;
        case ({r_prod[0], r_q})
            2'b01:   w_sum = w_hi_ext + w_a_ext;
            2'b10:   w_sum = w_hi_ext - w_a_ext;
            default: w_sum = w_hi_ext;
        endcase
    end
    assign w_mul_nxt = {w_sum, r_prod[WIDTH-1:1]};

    // Restoring step: top is the shifted remainder including its carry-out bit.
    assign w_top  = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_top - {1'b0, r_opnd};
    assign w_div_nxt = w_diff[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

    assign w_prod_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
    assign w_q_nxt    = r_prod[0];

    always_comb begin
        w_result_nxt = w_prod_nxt[WIDTH-1:0];
        w_exc_nxt    = 1'b0;
        if (!r_is_div) begin
            w_exc_nxt = !((&w_prod_nxt[2*WIDTH-1:WIDTH-1]) || ~(|w_prod_nxt[2*WIDTH-1:WIDTH-1]));
        end else if (r_div0) begin
            w_result_nxt = '0;
            w_exc_nxt    = 1'b1;
        end else begin
            w_result_nxt = r_neg ? -w_prod_nxt[WIDTH-1:0] : w_prod_nxt[WIDTH-1:0];
            w_exc_nxt    = r_dovf;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_resultRDY = (r_state == S_DONE);
        data_result    = r_result;
        data_exception = r_exc;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_q      <= 1'b0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_dovf   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_q      <= 1'b0;
            r_is_div <= !ctrl_MULT;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_div0   <= w_b_zero;
            r_dovf   <= w_ovf;
            if (ctrl_MULT) begin
                r_prod <= {{WIDTH{1'b0}}, data_operandB};
                r_opnd <= data_operandA;
            end else begin
                r_prod <= {{WIDTH{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
            end
        end else if (r_state == S_RUN) begin
            r_prod <= w_prod_nxt;
            r_q    <= w_q_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_result_nxt;
                r_exc    <= w_exc_nxt;
            end
        end
    end

endmodule
